// File: rtl/ysyx_23060203_wb_arb.sv
// Writeback arbiter: round-robin between the ALU/CSR path (A) and the load path (B)
// into one registered GPR write port, with a per-register pending-write scoreboard.
module ysyx_23060203_wb_arb #(
  parameter int NR_REG = 16,
  parameter int CNT_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wen,
  input  logic [4:0]        a_waddr,
  input  logic [31:0]       a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wen,
  input  logic [4:0]        b_waddr,
  input  logic [31:0]       b_wdata,
  output logic              gpr_wen,
  output logic [4:0]        gpr_waddr,
  output logic [31:0]       gpr_wdata,
  output logic              retire_valid,
  output logic              retire_src,
  input  logic              iss_valid,
  input  logic              iss_wen,
  input  logic [4:0]        iss_rd,
  output logic              iss_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [NR_REG-1:0] busy_map,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // x0 and indices beyond the tracked file are never written nor tracked
  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NR_REG);
  endfunction

  logic              last_grant;  // 0 = A, 1 = B
  logic              grant_a;
  logic              grant_b;
  logic              sel_wen;
  logic [4:0]        sel_addr;
  logic [31:0]       sel_data;
  logic [CNT_W-1:0]  cnt [NR_REG];
  logic [CNT_W-1:0]  rd_cnt;
  logic              do_set;
  logic [NR_REG-1:0] set_hit;
  logic [NR_REG-1:0] clr_hit;
  logic [NR_REG-1:0] underflow;

  always_comb begin
    grant_a  = !reset && a_valid && (!b_valid || last_grant);
    grant_b  = !reset && b_valid && (!a_valid || !last_grant);
    sel_wen  = grant_b ? b_wen   : a_wen;
    sel_addr = grant_b ? b_waddr : a_waddr;
    sel_data = grant_b ? b_wdata : a_wdata;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clock) begin
    if (reset)        last_grant <= 1'b1;
    else if (grant_a) last_grant <= 1'b0;
    else if (grant_b) last_grant <= 1'b1;
  end

  // ---- write stage boundary: granted payload registered toward the GPR file ----
  always_ff @(posedge clock) begin
    if (reset) begin
      gpr_wen      <= 1'b0;
      gpr_waddr    <= 5'd0;
      gpr_wdata    <= 32'd0;
      retire_valid <= 1'b0;
      retire_src   <= 1'b0;
    end else begin
      gpr_wen      <= (grant_a || grant_b) && sel_wen && reg_ok(sel_addr);
      retire_valid <= grant_a || grant_b;
      if (grant_a || grant_b) begin
        gpr_waddr  <= sel_addr;
        gpr_wdata  <= sel_data;
        retire_src <= grant_b;
      end
    end
  end

  // Busy lookups use the current count; the GPR write lands on the same edge as the clear
  always_comb begin
    rd_cnt   = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    busy_map = '0;
    for (int i = 0; i < NR_REG; i++) begin
      busy_map[i] = (cnt[i] != '0);
      if (i != 0) begin
        if (iss_rd == 5'(i)) rd_cnt   = cnt[i];
        if (rs1 == 5'(i))    rs1_busy = (cnt[i] != '0);
        if (rs2 == 5'(i))    rs2_busy = (cnt[i] != '0);
      end
    end
    iss_ready = !(iss_wen && (rd_cnt == CNT_MAX)) || (gpr_wen && (gpr_waddr == iss_rd));
    do_set    = iss_valid && iss_ready && iss_wen && reg_ok(iss_rd);
    for (int i = 0; i < NR_REG; i++) begin
      set_hit[i]   = do_set && (iss_rd == 5'(i));
      clr_hit[i]   = gpr_wen && (gpr_waddr == 5'(i));
      underflow[i] = clr_hit[i] && !set_hit[i] && (cnt[i] == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_err <= 1'b0;
      for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
    end else begin
      if (|underflow) sb_err <= 1'b1;
      for (int i = 0; i < NR_REG; i++) begin
        if (set_hit[i] && !clr_hit[i])                    cnt[i] <= cnt[i] + 1'b1;
        else if (clr_hit[i] && !set_hit[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule
